// File: rtl/restador_serie.sv
`default_nettype none
// ============================================================================
// Module   : restador_serie
// Purpose  : Digit-serial A - B (A + ~B + 1) with flags, saturation and
//            valid/ready handshake on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module restador_serie #(
    parameter int ANCHO  = 16,
    parameter int DIGITO = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valido,
    output logic             in_listo,
    input  logic [ANCHO-1:0] minuendo,
    input  logic [ANCHO-1:0] sustraendo,
    input  logic             modo_signo,
    input  logic             saturar,
    output logic             out_valido,
    input  logic             out_listo,
    output logic [ANCHO-1:0] restador,
    output logic             C_out,
    output logic             desbordamiento,
    output logic             cero,
    output logic             ocupado
);

    localparam int c_N  = ANCHO / DIGITO;
    localparam int c_CW = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_CW-1:0] c_ULTIMO = c_CW'(c_N - 1);

    typedef enum logic [1:0] {
        LIBRE   = 2'd0,
        CALCULO = 2'd1,
        ENTREGA = 2'd2
    } estado_t;

    estado_t r_estado;
    estado_t w_estado_sig;

    logic [ANCHO-1:0] r_a;
    logic [ANCHO-1:0] r_nb;
    logic [ANCHO-1:0] r_res;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_signo;
    logic             r_sat;
    logic             r_carry;
    logic [c_CW-1:0]  r_cnt;

    logic [ANCHO-1:0] r_restador;
    logic             r_c;
    logic             r_ovf;
    logic             r_cero;
    logic             r_out_valido;

    logic             w_acepta;
    logic [DIGITO:0]  w_suma;
    logic [ANCHO-1:0] w_res_sig;
    logic             w_ovf;
    logic [ANCHO-1:0] w_sat_val;
    logic [ANCHO-1:0] w_final;

    assign in_listo   = (r_estado == LIBRE) && !rst;
    assign w_acepta   = in_valido && in_listo;
    assign ocupado    = (r_estado != LIBRE);
    assign out_valido = r_out_valido;
    assign restador   = r_restador;
    assign C_out      = r_c;
    assign desbordamiento = r_ovf;
    assign cero       = r_cero;

    // Operands shift right each cycle so the active chunk is always bits [DIGITO-1:0];
    // the result fills from the top so after N cycles chunk 0 sits at the LSB.
    assign w_suma    = {1'b0, r_a[DIGITO-1:0]} + {1'b0, r_nb[DIGITO-1:0]}
                     + {{DIGITO{1'b0}}, r_carry};
    assign w_res_sig = (ANCHO'(w_suma[DIGITO-1:0]) << (ANCHO - DIGITO)) | (r_res >> DIGITO);

    assign w_ovf     = r_signo ? ((r_a_msb != r_b_msb) && (r_res[ANCHO-1] != r_a_msb))
                               : ~r_carry;
    assign w_sat_val = r_signo ? {r_a_msb, {(ANCHO-1){~r_a_msb}}} : '0;
    assign w_final   = (r_sat && w_ovf) ? w_sat_val : r_res;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado <= LIBRE;
        end else begin
            r_estado <= w_estado_sig;
        end
    end

    always_comb begin
        w_estado_sig = r_estado;
        case (r_estado)
            LIBRE:   if (w_acepta) w_estado_sig = CALCULO;
            CALCULO: if (r_cnt == c_ULTIMO) w_estado_sig = ENTREGA;
            ENTREGA: if (r_out_valido && out_listo) w_estado_sig = LIBRE;
            default: w_estado_sig = LIBRE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a          <= '0;
            r_nb         <= '0;
            r_res        <= '0;
            r_a_msb      <= 1'b0;
            r_b_msb      <= 1'b0;
            r_signo      <= 1'b0;
            r_sat        <= 1'b0;
            r_carry      <= 1'b0;
            r_cnt        <= '0;
            r_restador   <= '0;
            r_c          <= 1'b0;
            r_ovf        <= 1'b0;
            r_cero       <= 1'b0;
            r_out_valido <= 1'b0;
        end else begin
            case (r_estado)
                LIBRE: begin
                    if (w_acepta) begin
                        r_a     <= minuendo;
                        r_nb    <= ~sustraendo;
                        r_a_msb <= minuendo[ANCHO-1];
                        r_b_msb <= sustraendo[ANCHO-1];
                        r_signo <= modo_signo;
                        r_sat   <= saturar;
                        r_carry <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                CALCULO: begin
                    r_a     <= r_a >> DIGITO;
                    r_nb    <= r_nb >> DIGITO;
                    r_res   <= w_res_sig;
                    r_carry <= w_suma[DIGITO];
                    r_cnt   <= r_cnt + 1'b1;
                end
                ENTREGA: begin
                    // First ENTREGA cycle registers flags and saturation; out_valido follows.
                    if (!r_out_valido) begin
                        r_restador   <= w_final;
                        r_c          <= r_carry;
                        r_ovf        <= w_ovf;
                        r_cero       <= (w_final == '0);
                        r_out_valido <= 1'b1;
                    end else if (out_listo) begin
                        r_out_valido <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_restador_serie.sv
`default_nettype none
// ============================================================================
// Module   : tb_restador_serie
// Purpose  : Scoreboard bench for restador_serie (ANCHO=16, DIGITO=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_restador_serie;

    localparam int c_N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valido;
    logic        in_listo;
    logic [15:0] minuendo;
    logic [15:0] sustraendo;
    logic        modo_signo;
    logic        saturar;
    logic        out_valido;
    logic        out_listo;
    logic [15:0] restador;
    logic        C_out;
    logic        desbordamiento;
    logic        cero;
    logic        ocupado;

    restador_serie #(.ANCHO(16), .DIGITO(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valido      (in_valido),
        .in_listo       (in_listo),
        .minuendo       (minuendo),
        .sustraendo     (sustraendo),
        .modo_signo     (modo_signo),
        .saturar        (saturar),
        .out_valido     (out_valido),
        .out_listo      (out_listo),
        .restador       (restador),
        .C_out          (C_out),
        .desbordamiento (desbordamiento),
        .cero           (cero),
        .ocupado        (ocupado)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        logic        c;
        logic        o;
        logic        z;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   rise_last = -1;
    int   rise_prev = -1;
    logic        prev_v = 1'b0;
    logic [18:0] held;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops on each new result, checks stability while held.
    always @(negedge clk) begin
        exp_t e;
        logic [18:0] got;
        got = {restador, C_out, desbordamiento, cero};
        if (out_valido) begin
            n_cmp++;
            if (in_listo) begin
                n_err++;
                $display("FAIL in_listo_during_entrega: got %0b want 0", in_listo);
            end
            if (!prev_v) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_result: got res=%h with empty queue", restador);
                end else begin
                    e = q.pop_front();
                    if (got !== {e.res, e.c, e.o, e.z}) begin
                        n_err++;
                        $display("FAIL result: got res=%h c=%0b ovf=%0b z=%0b want res=%h c=%0b ovf=%0b z=%0b",
                                 restador, C_out, desbordamiento, cero, e.res, e.c, e.o, e.z);
                    end
                    n_cmp++;
                    if (cyc - e.acc != c_N + 1) begin
                        n_err++;
                        $display("FAIL latency: got %0d want %0d", cyc - e.acc, c_N + 1);
                    end
                    rise_prev = rise_last;
                    rise_last = cyc;
                end
                held = got;
            end else begin
                n_cmp++;
                if (got !== held) begin
                    n_err++;
                    $display("FAIL hold_stable: got %h want %h", got, held);
                end
            end
        end
        prev_v = out_valido;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Presents operands and waits (bounded) for the accept edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic sat, input bit push, input logic [15:0] er,
                        input logic ec, input logic eo, input logic ez);
        minuendo   = a;
        sustraendo = b;
        modo_signo = s;
        saturar    = sat;
        in_valido  = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (in_listo) begin
                tick();
                if (push) q.push_back('{er, ec, eo, ez, cyc});
                return;
            end
            tick();
        end
        n_cmp++;
        n_err++;
        $display("FAIL accept_timeout: got in_listo=0 want 1");
    endtask

    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            if (q.size() == 0 && !out_valido) return;
            tick();
        end
        n_cmp++;
        n_err++;
        $display("FAIL drain_timeout: got %0d pending want 0", q.size());
    endtask

    task automatic op(input logic [15:0] a, input logic [15:0] b, input logic s,
                      input logic sat, input logic [15:0] er, input logic ec,
                      input logic eo, input logic ez);
        send(a, b, s, sat, 1'b1, er, ec, eo, ez);
        in_valido = 1'b0;
        drain();
    endtask

    initial begin
        rst = 1'b1; in_valido = 1'b0; out_listo = 1'b1;
        minuendo = '0; sustraendo = '0; modo_signo = 1'b0; saturar = 1'b0;
        repeat (3) tick();
        check("reset_in_listo", 32'(in_listo), 32'd0);
        check("reset_outputs", {11'd0, restador, C_out, desbordamiento, cero, out_valido, ocupado}, 32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_reset", 32'(in_listo), 32'd1);

        // Unsigned
        op(16'd5, 16'd3, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0);
        op(16'd3, 16'd5, 1'b0, 1'b0, 16'hFFFE, 1'b0, 1'b1, 1'b0);
        op(16'd3, 16'd5, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1);
        // Signed
        op(16'h7FFF, 16'hFFFF, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        op(16'h7FFF, 16'hFFFF, 1'b1, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        op(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0);
        op(16'hFFFE, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);

        // Backpressure with new operands pending
        out_listo = 1'b0;
        send(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h00FE, 1'b1, 1'b0, 1'b0);
        minuendo = 16'h0001; sustraendo = 16'h0001; in_valido = 1'b1;
        for (int k = 0; k < 50 && !out_valido; k++) tick();
        check("bp_valid_seen", 32'(out_valido), 32'd1);
        repeat (3) tick();
        check("bp_still_valid", 32'(out_valido), 32'd1);
        out_listo = 1'b1;
        tick();
        check("bp_retired", 32'(out_valido), 32'd0);
        check("bp_ready_again", 32'(in_listo), 32'd1);
        op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);

        // Reset during the second CALCULO cycle
        send(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        in_valido = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("abort_outputs", {11'd0, restador, C_out, desbordamiento, cero, out_valido, ocupado}, 32'd0);
        check("abort_ready", 32'(in_listo), 32'd1);
        repeat (10) tick();
        op(16'h1234, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);

        // Back-to-back with in_valido held high
        send(16'd10, 16'd4, 1'b0, 1'b0, 1'b1, 16'h0006, 1'b1, 1'b0, 1'b0);
        send(16'd4, 16'd10, 1'b0, 1'b0, 1'b1, 16'hFFFA, 1'b0, 1'b1, 1'b0);
        in_valido = 1'b0;
        drain();
        n_cmp++;
        if (rise_last - rise_prev < c_N + 2) begin
            n_err++;
            $display("FAIL b2b_spacing: got %0d want >= %0d", rise_last - rise_prev, c_N + 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
